// File: rtl/serial_subtract_controller.sv
// serial_subtract_controller: wide unsigned subtraction done one nibble per
// cycle on a single 4-bit subtractor, LSB nibble first, with the borrow
// carried between nibbles in a register and a start/ready/done handshake.

// 4-bit subtract with borrow: {borrowOut, xy} = x - y - borrowIn (mod 32).
module FourBitSubtractor (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       borrowIn,
    output logic [3:0] xy,
    output logic       borrowOut
);
    logic [4:0] w_diff;

    // A 5-bit difference exposes the borrow as its top bit.
    assign w_diff    = {1'b0, x} - {1'b0, y} - {4'b0000, borrowIn};
    assign xy        = w_diff[3:0];
    assign borrowOut = w_diff[4];
endmodule

module serial_subtract_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrowOut
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_borrow;
    logic             r_borrow_out;
    logic [CW-1:0]    r_cnt;

    logic [3:0]       w_xy;
    logic             w_nib_borrow;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_accept;
    logic             w_last;

    // Shared nibble datapath.
    FourBitSubtractor u_sub (
        .x         (r_a_sh[3:0]),
        .y         (r_b_sh[3:0]),
        .borrowIn  (r_borrow),
        .xy        (w_xy),
        .borrowOut (w_nib_borrow)
    );

    // Accumulator with the current nibble slot replaced by the fresh difference;
    // also used directly as the final result so the last nibble needs no extra cycle.
    for (genvar gi = 0; gi < N; gi++) begin : g_nib
        assign w_acc_next[gi*4 +: 4] = (r_cnt == CW'(gi)) ? w_xy : r_acc[gi*4 +: 4];
    end

    assign w_last    = (r_cnt == LAST_NIB);
    assign result    = r_result;
    assign borrowOut = r_borrow_out;

    // Next-state and handshake decode; ready/busy/done depend on state only.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready    = 1'b1;
                w_accept = start;
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                ready        = 1'b1;
                done         = 1'b1;
                w_accept     = start;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Operand load, per-nibble shift/accumulate, and result capture on the last nibble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_acc        <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= borrowIn;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_next;
            r_borrow <= w_nib_borrow;
            r_a_sh   <= r_a_sh >> 4;
            r_b_sh   <= r_b_sh >> 4;
            if (w_last) begin
                r_result     <= w_acc_next;
                r_borrow_out <= w_nib_borrow;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule
